dcache_store_port_arbiter: RTL and testbench
============================================

// Module: dcache_store_port_arbiter
// PURPOSE
//  Shares one D$ store request port (data_req/data_gnt/data_rvalid) between NUM_PORTS requesters.
//  Requesters are the store buffer, the AMO buffer and later cache-maintenance logic.
//  Sits between the store unit's buffers and the D$ port.
//  Arbitrates round-robin, holds the chosen request stable until granted, and tracks outstanding
//  requests in order so each data_rvalid is routed back to the requester that issued it.
// PARAMETERS
//  NUM_PORTS        2   number of requesters (>=2)
//  MAX_OUTSTANDING  4   granted-but-unanswered requests tracked (power of 2, >=2)
//  ADDR_W           56  request address width (riscv::PLEN)
//  DATA_W           64  write data width (riscv::XLEN)
// PORTS
//  clk_i           in   1                    clock
//  rst_i           in   1                    asynchronous reset, active-high
//  req_i           in   NUM_PORTS            per-port request valid
//  addr_i          in   NUM_PORTS*ADDR_W     per-port address
//  wdata_i         in   NUM_PORTS*DATA_W     per-port write data
//  be_i            in   NUM_PORTS*DATA_W/8   per-port byte enables
//  size_i          in   NUM_PORTS*2          per-port transfer size
//  gnt_o           out  NUM_PORTS            per-port grant, one-hot or zero
//  rvalid_o        out  NUM_PORTS            per-port response valid, one-hot or zero
//  dc_req_o        out  1                    downstream request valid
//  dc_addr_o       out  ADDR_W               downstream address
//  dc_wdata_o      out  DATA_W               downstream write data
//  dc_be_o         out  DATA_W/8             downstream byte enables
//  dc_size_o       out  2                    downstream transfer size
//  dc_gnt_i        in   1                    downstream grant
//  dc_rvalid_i     in   1                    downstream response valid
//  idle_o          out  1                    no lock held and no outstanding requests
//  err_o           out  1                    sticky: dc_rvalid_i arrived with nothing outstanding
// BEHAVIOUR
//  Reset values:
//   - gnt_o=0, rvalid_o=0, dc_req_o=0, dc_* payload=0.
//   - idle_o=1, err_o=0.
//   - RR pointer=0, lock cleared, ID FIFO empty.
//  Arbitration (no lock):
//   - Select the first requesting port at or after the RR pointer, wrapping modulo NUM_PORTS.
//   - dc_req_o=1 in the same cycle; payload is muxed combinationally from the selected port.
//  Lock:
//   - If dc_req_o=1 and dc_gnt_i=0, latch the selected index.
//   - Later cycles serve the locked port only; RR is not re-evaluated.
//   - Requesters must hold req/payload stable until granted.
//  Handshake:
//   - On dc_req_o && dc_gnt_i: gnt_o[sel]=1 in the same cycle.
//   - Push sel into the ID FIFO, clear the lock, set RR pointer to sel+1 (wraps).
//  Full:
//   - When the FIFO holds MAX_OUTSTANDING entries, dc_req_o=0 and gnt_o=0.
//   - A held lock is kept.
//  Responses:
//   - On dc_rvalid_i: rvalid_o[fifo head]=1 in the same cycle, then pop.
//   - Responses are assumed in order.
//  Simultaneous push and pop: allowed; occupancy is unchanged.
//   - When full, a pop in cycle N permits a grant in cycle N+1 (no same-cycle bypass).
//  Empty error: dc_rvalid_i with an empty FIFO
//   - Sets err_o (sticky until reset).
//   - rvalid_o stays 0 and the FIFO is unchanged.
//  Lock wrap: locked port dropping req before grant is a protocol violation; lock still held.
//  Reset mid-operation: lock and FIFO cleared immediately; D$ responses after reset flagged as err.
//  idle_o = !lock_q && fifo_empty.
// CONFIGURATION
//  STORE_ARB_FIXED_PRIO_EN defined:
//   - Strict fixed priority, port 0 highest; RR pointer is not instantiated.
//   - Lock rules are unchanged.
//  Not defined: round-robin as above.
// STRUCTURE
//  ariane_pkg: add localparam DC_ARB_MAX_OUTSTANDING=4.
//  ariane_pkg: add typedef dc_arb_req_t {addr, wdata, be, size} so per-port payloads are arrays.
//  Sub-module arb_id_fifo:
//   - Depth MAX_OUTSTANDING, width $clog2(NUM_PORTS).
//   - Ports push/pop/full/empty/head; asynchronous active-high reset.
//  Arbiter logic, lock and RR pointer stay in this module.
// TESTING
//  1. Port0 and port1 request together, dc_gnt_i=1, RR=0
//     -> gnt_o=01, then next cycle gnt_o=10, then rvalid x2 -> rvalid_o=01 then 10.
//  2. Port1 requests, dc_gnt_i=0 for 3 cycles, port0 raises req in cycle 1
//     -> dc_addr_o stays port1's for all 3 cycles; gnt_o=10 in cycle 4.
//  3. Four grants to port0 with no rvalid
//     -> cycle 5 dc_req_o=0; rvalid in cycle 5 -> rvalid_o=01; grant resumes cycle 6.
//  4. dc_rvalid_i=1 with FIFO empty -> rvalid_o=00, err_o=1 and stays 1 until rst_i.
//  5. rst_i asserted with 2 outstanding and a lock held
//     -> idle_o=1 and dc_req_o=0 while rst_i high; next rvalid -> err_o=1.
//  6. STORE_ARB_FIXED_PRIO_EN, both ports request continuously
//     -> port0 granted every cycle, port1 never, until port0 drops req.

Source files
------------

// File: rtl/dcache_store_port_arbiter_pkg.sv
// Shared constants and the per-port store request payload type for the D$ store port arbiter.
package dcache_store_port_arbiter_pkg;

  localparam int DC_ARB_MAX_OUTSTANDING = 4;
  localparam int DC_ARB_ADDR_W          = 56;
  localparam int DC_ARB_DATA_W          = 64;

  typedef struct packed {
    logic [DC_ARB_ADDR_W-1:0]   addr;
    logic [DC_ARB_DATA_W-1:0]   wdata;
    logic [DC_ARB_DATA_W/8-1:0] be;
    logic [1:0]                 size;
  } dc_arb_req_t;

endpackage

// File: rtl/dcache_store_port_arbiter_id_fifo.sv
// In-order FIFO of requester indices for granted-but-unanswered D$ store requests.
module arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_q, rd_q, wr_d, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign head_o  = mem_q[rd_q[PTR_W-1:0]];

  assign wr_d = push_i ? wr_q + 1'b1 : wr_q;
  assign rd_d = pop_i  ? rd_q + 1'b1 : rd_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone define valid entries.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[PTR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/dcache_store_port_arbiter.sv
// Shares one D$ store port among NUM_PORTS requesters with lock-until-grant and in-order response routing.
// Define STORE_ARB_FIXED_PRIO_EN for strict fixed priority (port 0 highest) instead of round-robin.
module dcache_store_port_arbiter
  import dcache_store_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int MAX_OUTSTANDING = DC_ARB_MAX_OUTSTANDING,
  parameter int ADDR_W          = DC_ARB_ADDR_W,
  parameter int DATA_W          = DC_ARB_DATA_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata_i,
  input  logic [NUM_PORTS*DATA_W/8-1:0] be_i,
  input  logic [NUM_PORTS*2-1:0]        size_i,
  output logic [NUM_PORTS-1:0]          gnt_o,
  output logic [NUM_PORTS-1:0]          rvalid_o,
  output logic                          dc_req_o,
  output logic [ADDR_W-1:0]             dc_addr_o,
  output logic [DATA_W-1:0]             dc_wdata_o,
  output logic [DATA_W/8-1:0]           dc_be_o,
  output logic [1:0]                    dc_size_o,
  input  logic                          dc_gnt_i,
  input  logic                          dc_rvalid_i,
  output logic                          idle_o,
  output logic                          err_o
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int BE_W  = DATA_W / 8;

  dc_arb_req_t      port_req [NUM_PORTS];
  dc_arb_req_t      dc_payload;
  logic [IDX_W-1:0] rr_start, rr_sel, sel, lock_idx_q, lock_idx_d, fifo_head;
  logic             rr_found, lock_q, lock_d, err_q, err_d;
  logic             fifo_full, fifo_empty, handshake, pop;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_req[i].addr  = addr_i[i*ADDR_W +: ADDR_W];
      port_req[i].wdata = wdata_i[i*DATA_W +: DATA_W];
      port_req[i].be    = be_i[i*BE_W +: BE_W];
      port_req[i].size  = size_i[i*2 +: 2];
    end
  end

`ifdef STORE_ARB_FIXED_PRIO_EN
  assign rr_start = '0;
`else
  logic [IDX_W-1:0] rr_q, rr_d;

  assign rr_start = rr_q;
  assign rr_d     = (int'(sel) == NUM_PORTS - 1) ? '0 : sel + IDX_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          rr_q <= '0;
    else if (handshake) rr_q <= rr_d;
  end
`endif

  // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_sel   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(rr_start) + k) % NUM_PORTS;
      if (!rr_found && req_i[idx]) begin
        rr_found = 1'b1;
        rr_sel   = IDX_W'(idx);
      end
    end
  end

  // A held lock keeps serving its port even if that port misbehaves and drops req.
  assign sel        = lock_q ? lock_idx_q : rr_sel;
  assign dc_req_o   = !rst_i && (lock_q || rr_found) && !fifo_full;
  assign handshake  = dc_req_o && dc_gnt_i;
  assign pop        = !rst_i && dc_rvalid_i && !fifo_empty;

  assign dc_payload = dc_req_o ? port_req[sel] : '0;
  assign dc_addr_o  = dc_payload.addr;
  assign dc_wdata_o = dc_payload.wdata;
  assign dc_be_o    = dc_payload.be;
  assign dc_size_o  = dc_payload.size;

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (handshake) gnt_o[sel]          = 1'b1;
    if (pop)       rvalid_o[fifo_head] = 1'b1;
  end

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (handshake) begin
      lock_d = 1'b0;
    end else if (dc_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end
    err_d = err_q || (dc_rvalid_i && fifo_empty);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

  assign idle_o = !lock_q && fifo_empty;
  assign err_o  = err_q;

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .data_i  (sel),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

endmodule

// File: tb/tb_dcache_store_port_arbiter.sv
// Scoreboard bench: a queue-based model of the store port arbiter predicts grants, responses and status.
module tb_dcache_store_port_arbiter;

  localparam int N    = 2;
  localparam int MAXO = 4;
  localparam int AW   = 56;
  localparam int DW   = 64;
  localparam int BW   = DW / 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_i;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] wdata_i;
  logic [N*BW-1:0] be_i;
  logic [N*2-1:0]  size_i;
  logic [N-1:0]    gnt_o, rvalid_o;
  logic            dc_req_o;
  logic [AW-1:0]   dc_addr_o;
  logic [DW-1:0]   dc_wdata_o;
  logic [BW-1:0]   dc_be_o;
  logic [1:0]      dc_size_o;
  logic            dc_gnt_i, dc_rvalid_i, idle_o, err_o;

  always #5 clk_i = ~clk_i;

  dcache_store_port_arbiter #(
    .NUM_PORTS(N), .MAX_OUTSTANDING(MAXO), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .be_i(be_i), .size_i(size_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .dc_req_o(dc_req_o),
    .dc_addr_o(dc_addr_o), .dc_wdata_o(dc_wdata_o), .dc_be_o(dc_be_o), .dc_size_o(dc_size_o),
    .dc_gnt_i(dc_gnt_i), .dc_rvalid_i(dc_rvalid_i), .idle_o(idle_o), .err_o(err_o)
  );

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic [1:0]    size;
  } gnt_exp_t;

  typedef struct {
    logic          req;
    logic [AW-1:0] addr;
    logic          idle;
    logic          err;
  } stat_exp_t;

  gnt_exp_t  gnt_q[$];
  int        rsp_q[$];
  stat_exp_t stat_q[$];
  gnt_exp_t  mon_g;
  stat_exp_t mon_s;
  int        mon_p;

  // Requester state and abstract arbiter model.
  logic          active [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_wdata[N];
  logic [BW-1:0] p_be   [N];
  logic [1:0]    p_size [N];
  int            out_q[$];
  int            locked, rr;
  logic          err_m;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_ports();
    for (int p = 0; p < N; p++) begin
      req_i[p]              = active[p];
      addr_i[p*AW +: AW]    = p_addr[p];
      wdata_i[p*DW +: DW]   = p_wdata[p];
      be_i[p*BW +: BW]      = p_be[p];
      size_i[p*2 +: 2]      = p_size[p];
    end
  endtask

  task automatic model_clear();
    out_q.delete();
    locked = -1;
    rr     = 0;
    err_m  = 1'b0;
    for (int p = 0; p < N; p++) begin
      active[p]  = 1'b0;
      p_addr[p]  = '0;
      p_wdata[p] = '0;
      p_be[p]    = '0;
      p_size[p]  = '0;
    end
  endtask

  // One clock cycle: raise new requests from mask, drive D$ handshake, predict the outcome.
  task automatic step(input logic [N-1:0] mask, input logic gnt, input logic rv);
    int        cand, start;
    stat_exp_t s;
    gnt_exp_t  g;
    @(posedge clk_i);
    #1;
    for (int p = 0; p < N; p++) begin
      if (mask[p] && !active[p]) begin
        active[p]  = 1'b1;
        p_addr[p]  = AW'({$urandom(), $urandom()});
        p_wdata[p] = {$urandom(), $urandom()};
        p_be[p]    = BW'($urandom());
        p_size[p]  = 2'($urandom());
      end
    end
    drive_ports();
    dc_gnt_i    = gnt;
    dc_rvalid_i = rv;

    s.idle = (locked < 0) && (out_q.size() == 0);
    s.err  = err_m;
`ifdef STORE_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = rr;
`endif
    cand = -1;
    if (out_q.size() < MAXO) begin
      if (locked >= 0) cand = locked;
      else
        for (int k = 0; k < N; k++)
          if (cand < 0 && active[(start + k) % N]) cand = (start + k) % N;
    end
    s.req  = (cand >= 0);
    s.addr = (cand >= 0) ? p_addr[cand] : '0;
    stat_q.push_back(s);

    if (rv) begin
      if (out_q.size() > 0) rsp_q.push_back(out_q.pop_front());
      else                  err_m = 1'b1;
    end
    if (cand >= 0) begin
      if (gnt) begin
        g.port  = cand;
        g.addr  = p_addr[cand];
        g.wdata = p_wdata[cand];
        g.be    = p_be[cand];
        g.size  = p_size[cand];
        gnt_q.push_back(g);
        out_q.push_back(cand);
        active[cand] = 1'b0;
        locked       = -1;
        rr           = (cand + 1) % N;
      end else begin
        locked = cand;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (out_q.size() == 0 && locked < 0 && !active[0] && !active[1]) break;
      step('0, 1'b1, out_q.size() > 0);
    end
  endtask

  // Asserts reset mid-operation with the current requests still driven.
  task automatic do_reset();
    @(posedge clk_i);
    #1;
    rst_i       = 1'b1;
    dc_gnt_i    = 1'b0;
    dc_rvalid_i = 1'b0;
    #2;
    check("rst_idle", idle_o, 1'b1);
    check("rst_dc_req", dc_req_o, 1'b0);
    check("rst_gnt", gnt_o, '0);
    check("pending_at_reset", 128'(gnt_q.size() + rsp_q.size()), 0);
    gnt_q.delete();
    rsp_q.delete();
    model_clear();
    drive_ports();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (stat_q.size() > 0) begin
        mon_s = stat_q.pop_front();
        check("dc_req", dc_req_o, mon_s.req);
        check("idle", idle_o, mon_s.idle);
        check("err", err_o, mon_s.err);
        if (mon_s.req) check("dc_addr_held", dc_addr_o, mon_s.addr);
      end
      if (gnt_o != '0) begin
        if (gnt_q.size() == 0) check("gnt_unexpected", gnt_o, '0);
        else begin
          mon_g = gnt_q.pop_front();
          check("gnt_o", gnt_o, 128'(1) << mon_g.port);
          check("dc_addr", dc_addr_o, mon_g.addr);
          check("dc_wdata", dc_wdata_o, mon_g.wdata);
          check("dc_be", dc_be_o, mon_g.be);
          check("dc_size", dc_size_o, mon_g.size);
        end
      end
      if (rvalid_o != '0) begin
        if (rsp_q.size() == 0) check("rvalid_unexpected", rvalid_o, '0);
        else begin
          mon_p = rsp_q.pop_front();
          check("rvalid_o", rvalid_o, 128'(1) << mon_p);
        end
      end
    end
  end

  initial begin
    rst_i       = 1'b1;
    dc_gnt_i    = 1'b0;
    dc_rvalid_i = 1'b0;
    model_clear();
    drive_ports();
    #12;
    check("reset_gnt", gnt_o, '0);
    check("reset_rvalid", rvalid_o, '0);
    check("reset_dc_req", dc_req_o, 1'b0);
    check("reset_payload", {dc_addr_o, dc_wdata_o, dc_be_o, dc_size_o}, '0);
    check("reset_idle", idle_o, 1'b1);
    check("reset_err", err_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Both request together, then responses in order.
    step(2'b11, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);

    // Port1 locked while stalled; port0 arriving later must not steal the port.
    step(2'b10, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    drain();

    // Fill all outstanding slots, then a response frees one for the following cycle.
    repeat (4) step(2'b01, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b1);
    step(2'b01, 1'b1, 1'b0);
    drain();

    // Response with nothing outstanding is flagged and sticky.
    step(2'b00, 1'b0, 1'b1);
    repeat (3) step(2'b00, 1'b0, 1'b0);
    do_reset();

    // Reset with two outstanding and a lock held; a stale response afterwards is an error.
    step(2'b01, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    do_reset();
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b0);
    do_reset();

    // Both ports requesting continuously.
    for (int i = 0; i < 12; i++) step(2'b11, 1'b1, out_q.size() > 0);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 800; i++)
      step(N'($urandom_range(0, 3)), ($urandom % 3) != 0, (out_q.size() > 0) && ($urandom % 2 == 1));
    drain();

    @(negedge clk_i);
    #1;
    check("gnt_q_drained", 128'(gnt_q.size()), 0);
    check("rsp_q_drained", 128'(rsp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
